// File: rtl/waveform_gen_core_pkg.sv
// -----------------------------------------------------------------------------
// waveform_gen_core_pkg
// Shared widths, wave-select encodings and the sine-table generator used by
// the function-generator datapath.
//   DIV_W     : divider width (divide value N = SW[7:0])
//   ADDR_W    : phase counter / sine ROM address width
//   DATA_W    : sample width
//   MID_SCALE : DC / default sample value
//   sine_sample(idx) : elaboration-time ROM contents,
//                      round(127.5 + 127.5*sin(2*pi*idx/1024))
// -----------------------------------------------------------------------------
package waveform_gen_core_pkg;

  localparam int DIV_W  = 8;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int SW_W   = 12;

  localparam logic [DATA_W-1:0] MID_SCALE = 8'h80;

  typedef enum logic [2:0] {
    WAVE_SAW    = 3'b000,
    WAVE_TRI    = 3'b001,
    WAVE_SQR    = 3'b010,
    WAVE_RAMPDN = 3'b011,
    WAVE_DC     = 3'b100
  } wave_sel_e;

  // Q30 fixed-point constants for the sine table generator.
  localparam longint SINE_ONE = 64'sd1073741824;  // 1.0
  localparam longint SINE_PI  = 64'sd3373259426;  // pi

  // Integer-only sine evaluation so the table can be built as constants at
  // elaboration.  The index is folded into the first quadrant (x in [0, pi/2])
  // and a Taylor series to x^17 keeps the error far below one LSB, so the
  // rounding matches a double-precision reference.
  function automatic logic [DATA_W-1:0] sine_sample(input int unsigned idx);
    int unsigned half;
    int unsigned quarter;
    int unsigned pos;
    int unsigned q;
    logic        neg;
    longint      x;
    longint      term;
    longint      s;
    longint      num;
    longint      r;
    half    = 1 << (ADDR_W - 1);
    quarter = 1 << (ADDR_W - 2);
    pos     = idx % half;
    neg     = ((idx % (2 * half)) >= half);
    q       = (pos <= quarter) ? pos : (half - pos);
    x       = (SINE_PI * longint'(q)) / longint'(half);
    s       = x;
    term    = x;
    for (int k = 1; k <= 8; k++) begin
      term = (term * x / SINE_ONE) / longint'(2 * k);
      term = -((term * x / SINE_ONE) / longint'(2 * k + 1));
      s    = s + term;
    end
    if (neg) s = -s;
    // 127.5*(1+s) rounded half-up == floor((255*(1+s) + 1) / 2) in Q30 units
    num = 64'sd255 * (SINE_ONE + s);
    r   = (num + SINE_ONE) / (64'sd2 * SINE_ONE);
    if (r < 0)   r = 0;
    if (r > 255) r = 255;
    return r[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/waveform_gen_core_sine_rom.sv
// -----------------------------------------------------------------------------
// sine_rom_1024x8
// Combinational full-period sine lookup table, contents generated at
// elaboration from waveform_gen_core_pkg::sine_sample.
//   addr_i [ADDR_W-1:0] : phase / table address
//   data_o [DATA_W-1:0] : unsigned sine sample (128 at 0, 255 at peak, 0 at trough)
// -----------------------------------------------------------------------------
module sine_rom_1024x8
  import waveform_gen_core_pkg::*;
(
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] data_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] rom [0:DEPTH-1];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    localparam logic [DATA_W-1:0] SAMPLE = sine_sample(gi);
    assign rom[gi] = SAMPLE;
  end

  assign data_o = rom[addr_i];

endmodule

// File: rtl/waveform_gen_core.sv
// -----------------------------------------------------------------------------
// waveform_gen_core
// Function-generator datapath: programmable down-counter divider -> toggle
// flip-flop -> 10-bit phase counter -> sine ROM / arithmetic wave generator
// -> output mux.  Switch bits are echoed for LEDs.
//   CLKOSILLATOR             : system clock, rising edge
//   RST                      : asynchronous active-high reset
//   INIT                     : 0 = divider load/hold, 1 = run
//   SW[11:0]                 : [7:0] divide N, [10:8] wave select, [11] mux select
//   CO                       : divider carry pulse (once every N+1 clocks)
//   OUTPUTJKFLIPFLOP         : divided clock, period 2(N+1)
//   MEMORYCOUNTER            : phase / ROM address
//   WAVESELECT, MUXSELESCT   : SW[10:8], SW[11] echoes
//   SW_0..SW_7, SW_8_..SW_10_: individual switch echoes
//   ROMOUTPUT                : sine sample
//   WAVEFORMEGENERATOROUTPUT : arithmetic wave sample
//   OUTPUTWAVE               : selected sample
// -----------------------------------------------------------------------------
module waveform_gen_core
  import waveform_gen_core_pkg::*;
(
  input  logic              CLKOSILLATOR,
  input  logic              RST,
  input  logic              INIT,
  input  logic [SW_W-1:0]   SW,
  output logic              CO,
  output logic              OUTPUTJKFLIPFLOP,
  output logic [ADDR_W-1:0] MEMORYCOUNTER,
  output logic [2:0]        WAVESELECT,
  output logic              MUXSELESCT,
  output logic              SW_0,
  output logic              SW_1,
  output logic              SW_2,
  output logic              SW_3,
  output logic              SW_4,
  output logic              SW_5,
  output logic              SW_6,
  output logic              SW_7,
  output logic              SW_8_,
  output logic              SW_9_,
  output logic              SW_10_,
  output logic [DATA_W-1:0] ROMOUTPUT,
  output logic [DATA_W-1:0] WAVEFORMEGENERATOROUTPUT,
  output logic [DATA_W-1:0] OUTPUTWAVE
);

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic              jk_q, jk_d;
  logic [ADDR_W-1:0] phase_q, phase_d;
  logic              co;
  logic [2:0]        wave_sel;
  logic [DATA_W-1:0] wave_sample;
  logic [DATA_W-1:0] rom_sample;

  assign wave_sel = SW[10:8];

  // Divider / toggle FF / phase next-state.  CO is combinational on the
  // current count so a count of zero fires immediately once INIT is high.
  always_comb begin
    co        = INIT && (div_cnt_q == '0);
    div_cnt_d = (!INIT || co) ? SW[DIV_W-1:0] : div_cnt_q - DIV_W'(1);
    jk_d      = co ? ~jk_q : jk_q;  // J = K = CO
    // One phase step per divided-clock period: only on the CO that takes
    // the toggle FF from 1 back to 0.
    phase_d   = (co && jk_q) ? phase_q + ADDR_W'(1) : phase_q;
  end

  always_ff @(posedge CLKOSILLATOR or posedge RST) begin
    if (RST) begin
      div_cnt_q <= '0;
      jk_q      <= 1'b0;
      phase_q   <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      jk_q      <= jk_d;
      phase_q   <= phase_d;
    end
  end

  sine_rom_1024x8 u_sine_rom (
    .addr_i (phase_q),
    .data_o (rom_sample)
  );

  // Arithmetic waves are derived directly from the top phase bits.
  always_comb begin
    wave_sample = MID_SCALE;
    case (wave_sel)
      WAVE_SAW:    wave_sample = phase_q[ADDR_W-1 -: DATA_W];
      WAVE_TRI:    wave_sample = phase_q[ADDR_W-1] ? ~phase_q[ADDR_W-2 -: DATA_W]
                                                   :  phase_q[ADDR_W-2 -: DATA_W];
      WAVE_SQR:    wave_sample = phase_q[ADDR_W-1] ? {DATA_W{1'b0}} : {DATA_W{1'b1}};
      WAVE_RAMPDN: wave_sample = ~phase_q[ADDR_W-1 -: DATA_W];
      WAVE_DC:     wave_sample = MID_SCALE;
      default:     wave_sample = MID_SCALE;
    endcase
  end

  assign CO                       = co;
  assign OUTPUTJKFLIPFLOP         = jk_q;
  assign MEMORYCOUNTER            = phase_q;
  assign ROMOUTPUT                = rom_sample;
  assign WAVEFORMEGENERATOROUTPUT = wave_sample;
  assign OUTPUTWAVE               = SW[11] ? rom_sample : wave_sample;

  assign WAVESELECT = wave_sel;
  assign MUXSELESCT = SW[11];
  assign SW_0       = SW[0];
  assign SW_1       = SW[1];
  assign SW_2       = SW[2];
  assign SW_3       = SW[3];
  assign SW_4       = SW[4];
  assign SW_5       = SW[5];
  assign SW_6       = SW[6];
  assign SW_7       = SW[7];
  assign SW_8_      = SW[8];
  assign SW_9_      = SW[9];
  assign SW_10_     = SW[10];

endmodule

// File: tb/tb_waveform_gen_core.sv
// -----------------------------------------------------------------------------
// tb_waveform_gen_core
// Scoreboard bench: a cycle model of divider / toggle FF / phase pushes the
// expected post-edge outputs each clock, popped and compared 1 ns after the
// rising edge.  Fixed spot values (triangle, sine, wave-select sweep, echoes,
// reset) are compared as constants.
// -----------------------------------------------------------------------------
module tb_waveform_gen_core;

  logic        clk;
  logic        rst;
  logic        init;
  logic [11:0] sw;

  logic        co_o, jk_o, msel_o;
  logic [9:0]  mc_o;
  logic [2:0]  wsel_o;
  logic        sw0, sw1, sw2, sw3, sw4, sw5, sw6, sw7, sw8, sw9, sw10;
  logic [7:0]  rom_o, gen_o, out_o;
  logic [10:0] echo;

  waveform_gen_core dut (
    .CLKOSILLATOR             (clk),
    .RST                      (rst),
    .INIT                     (init),
    .SW                       (sw),
    .CO                       (co_o),
    .OUTPUTJKFLIPFLOP         (jk_o),
    .MEMORYCOUNTER            (mc_o),
    .WAVESELECT               (wsel_o),
    .MUXSELESCT               (msel_o),
    .SW_0                     (sw0),
    .SW_1                     (sw1),
    .SW_2                     (sw2),
    .SW_3                     (sw3),
    .SW_4                     (sw4),
    .SW_5                     (sw5),
    .SW_6                     (sw6),
    .SW_7                     (sw7),
    .SW_8_                    (sw8),
    .SW_9_                    (sw9),
    .SW_10_                   (sw10),
    .ROMOUTPUT                (rom_o),
    .WAVEFORMEGENERATOROUTPUT (gen_o),
    .OUTPUTWAVE               (out_o)
  );

  assign echo = {sw10, sw9, sw8, sw7, sw6, sw5, sw4, sw3, sw2, sw1, sw0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       co;
    logic       ff;
    logic [9:0] mc;
    logic       wave_vld;
    logic [7:0] wave;
  } exp_t;

  exp_t sb_q[$];

  int n_cmp  = 0;
  int n_err  = 0;
  int co_seen = 0;
  int wraps  = 0;
  logic [9:0] prev_mc = '0;

  // cycle model state
  logic [7:0] m_cnt;
  logic       m_ff;
  logic [9:0] m_ph;

  logic [7:0] sweep_exp [8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_wave(input logic [2:0] sel, input logic [9:0] a);
    case (sel)
      3'd0:    return a[9:2];
      3'd1:    return a[9] ? ~a[8:1] : a[8:1];
      3'd2:    return a[9] ? 8'h00 : 8'hFF;
      3'd3:    return ~a[9:2];
      default: return 8'h80;
    endcase
  endfunction

  function automatic logic [7:0] ref_sine(input int a);
    real v;
    v = 127.5 + 127.5 * $sin(2.0 * 3.14159265358979 * a / 1024.0);
    return 8'($rtoi($floor(v + 0.5)));
  endfunction

  task automatic model_reset();
    m_cnt = '0;
    m_ff  = 1'b0;
    m_ph  = '0;
    sb_q.delete();
  endtask

  // One rising edge: update model, push expectation, then compare.
  task automatic cycle();
    exp_t e;
    exp_t g;
    logic mco;
    mco = init && (m_cnt == 8'd0);
    if (mco && m_ff) m_ph = m_ph + 10'd1;
    if (mco) m_ff = ~m_ff;
    m_cnt = (!init || mco) ? sw[7:0] : m_cnt - 8'd1;

    e.co = init && (m_cnt == 8'd0);
    e.ff = m_ff;
    e.mc = m_ph;
    if (sw[11]) begin
      e.wave_vld = (m_ph == 10'd128) || (m_ph == 10'd600) || (m_ph == 10'd900);
      e.wave     = ref_sine(int'(m_ph));
    end else begin
      e.wave_vld = 1'b1;
      e.wave     = ref_wave(sw[10:8], m_ph);
    end
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      g = sb_q.pop_front();
      chk("co", 32'(co_o), 32'(g.co));
      chk("ff", 32'(jk_o), 32'(g.ff));
      chk("mc", 32'(mc_o), 32'(g.mc));
      if (g.wave_vld) chk("wave", 32'(out_o), 32'(g.wave));
    end
    if (co_o) co_seen++;
    if (prev_mc == 10'd1023 && mc_o == 10'd0) wraps++;
    prev_mc = mc_o;

    if (!sw[11] && sw[10:8] == 3'b001) begin
      case (m_ph)
        10'd0:    chk("tri_0",    32'(out_o), 32'h00);
        10'd511:  chk("tri_511",  32'(out_o), 32'hFF);
        10'd512:  chk("tri_512",  32'(out_o), 32'hFF);
        10'd1023: chk("tri_1023", 32'(out_o), 32'h00);
        default: ;
      endcase
    end
    if (sw[11]) begin
      case (m_ph)
        10'd0:   begin chk("rom_0",   32'(out_o), 32'd128); chk("romo_0",   32'(rom_o), 32'd128); end
        10'd256: begin chk("rom_256", 32'(out_o), 32'd255); chk("romo_256", 32'(rom_o), 32'd255); end
        10'd768: begin chk("rom_768", 32'(out_o), 32'd0);   chk("romo_768", 32'(rom_o), 32'd0);   end
        default: ;
      endcase
    end
  endtask

  initial begin
    int n;
    sweep_exp = '{8'h96, 8'hD3, 8'h00, 8'h69, 8'h80, 8'h80, 8'h80, 8'h80};

    // Reset state
    rst  = 1'b1;
    init = 1'b0;
    sw   = 12'h102;
    #2;
    chk("rst_co",   32'(co_o),   32'd0);
    chk("rst_ff",   32'(jk_o),   32'd0);
    chk("rst_mc",   32'(mc_o),   32'd0);
    chk("rst_echo", 32'(echo),   32'h102);
    chk("rst_wsel", 32'(wsel_o), 32'd1);
    chk("rst_msel", 32'(msel_o), 32'd0);
    chk("rst_out",  32'(out_o),  32'h00);
    $display("reset state checked");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // INIT=0 hold, then run at N=2
    repeat (3) cycle();
    $display("init=0 hold: co_seen=%0d", co_seen);
    chk("co_hold", 32'(co_seen), 32'd0);
    init = 1'b1;
    co_seen = 0;
    repeat (30) cycle();
    chk("co_1in3", 32'(co_seen), 32'd10);
    $display("N=2 run: co pulses=%0d mc=%0d", co_seen, mc_o);

    // Asynchronous reset mid-run: clears without a clock edge
    rst = 1'b1;
    #1;
    chk("arst_mc",   32'(mc_o), 32'd0);
    chk("arst_ff",   32'(jk_o), 32'd0);
    chk("arst_co",   32'(co_o), 32'd1);
    chk("arst_echo", 32'(echo), 32'h102);
    #3;
    rst = 1'b0;
    model_reset();
    repeat (12) cycle();
    $display("after async reset: mc=%0d", mc_o);

    // N=0, triangle, mux=arith: full wrap
    sw = 12'h100;
    wraps = 0;
    repeat (2100) cycle();
    chk("wrap_cnt", 32'(wraps), 32'd1);
    $display("N=0 triangle sweep: wraps=%0d", wraps);

    // N=0, sine ROM on output
    sw = 12'h900;
    repeat (2100) cycle();
    $display("N=0 sine sweep done: mc=%0d", mc_o);

    // Park phase at 600 and sweep wave select
    sw = 12'h000;
    n = 0;
    while (m_ph != 10'd600 && n < 2100) begin
      cycle();
      n++;
    end
    chk("reach600", 32'(mc_o), 32'd600);
    init = 1'b0;
    repeat (2) cycle();
    for (int i = 0; i < 8; i++) begin
      sw = {1'b0, 3'(i), 8'h00};
      #1;
      chk($sformatf("sweep_out%0d", i), 32'(out_o),  32'(sweep_exp[i]));
      chk($sformatf("sweep_gen%0d", i), 32'(gen_o),  32'(sweep_exp[i]));
      chk($sformatf("sweep_sel%0d", i), 32'(wsel_o), 32'(i));
      $display("sweep sel=%0d out=%0h", i, out_o);
    end
    chk("hold600", 32'(mc_o), 32'd600);

    // Echoes remain live during reset
    rst = 1'b1;
    sw  = 12'hA5C;
    #1;
    chk("echo_rst",   32'(echo),   32'h25C);
    chk("wsel_rst",   32'(wsel_o), 32'd2);
    chk("msel_rst",   32'(msel_o), 32'd1);
    chk("mc_rst2",    32'(mc_o),   32'd0);
    chk("romout_rst", 32'(out_o),  32'd128);
    $display("echo under reset checked");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
